// File: rtl/uart_rom_loader_pkg.sv
// Shared types and constants for the UART ROM boot loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_rom_loader_pkg;

    localparam int          INST_ADDR_BUS    = 32;
    localparam int          INST_DATA_BUS    = 32;
    localparam int          ROM_NUM          = 4096;
    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;

    // Frame-level loader states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } ld_state_t;

    // Bit-level receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Byte address of a ROM word index
    function automatic logic [INST_ADDR_BUS-1:0] word_addr(input logic [INST_ADDR_BUS-1:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM write port plus loader status, driven by the loader towards the ROM/core.
// Latency: n/a (wires only).
// Backpressure: none; the ROM write port must accept a write every cycle.
interface uart_rom_loader_if;
    import uart_rom_loader_pkg::*;

    logic                     wr_en;
    logic [INST_ADDR_BUS-1:0] wr_addr;
    logic [INST_DATA_BUS-1:0] wr_data;
    logic                     busy;
    logic                     done;
    logic                     err;

    modport master (
        output wr_en, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, busy, done, err
    );

endinterface

// File: rtl/uart_rom_loader_uart_rx.sv
// UART 8N1 receiver: synchronises the line, samples each bit mid-period, emits one byte per frame.
// Latency: rx_valid/frame_err pulse one cycle after the stop bit's mid-point sample.
// Backpressure: none; the consumer must take rx_data on the rx_valid pulse.
module uart_rx
    import uart_rom_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Next-state: synchroniser, start detect, mid-bit sampling of data and stop bits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        sync1_d = rx_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A glitch that is already high again at half-bit is not a start bit
                    state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = sync2_q;
                    ferr_d  = !sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // State registers; synchroniser resets to the idle-high line level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid  = valid_q;
    assign rx_data   = shift_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/uart_rom_loader.sv
// Boot loader: receives A5|LEN_LO|LEN_HI|LEN words|[CSUM] over UART and writes ROM words 0..LEN-1.
// Latency: ROM write one cycle after the 4th byte of each word; busy_o holds the core while loading.
// Backpressure: none; optional trailing checksum enabled by LOADER_CHECKSUM_EN.
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int ROM_WORDS   = ROM_NUM,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               uart_rx_i,
    uart_rom_loader_if.master  rom
);

    localparam int IDX_W = $clog2(ROM_WORDS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       frame_err;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (uart_rx_i),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .frame_err (frame_err)
    );

    ld_state_t                state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [IDX_W-1:0]         word_idx_q, word_idx_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [31:0]              asm_q, asm_d;
    logic [TO_W-1:0]          idle_q, idle_d;
    logic                     wr_en_q, wr_en_d;
    logic [INST_ADDR_BUS-1:0] wr_addr_q, wr_addr_d;
    logic [INST_DATA_BUS-1:0] wr_data_q, wr_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               csum_q, csum_d;
`endif

    logic        in_frame;
    logic [15:0] new_len;

    assign in_frame = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign new_len  = {rx_data, len_q[7:0]};

    // Frame FSM: sync/length parsing, word assembly and ROM writes, abort on line error or silence
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        idle_d     = idle_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        if (in_frame) begin
            idle_d = rx_valid ? '0 : idle_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // Only the sync byte starts a frame; status of the last frame is held otherwise
                if (rx_valid && rx_data == LOADER_SYNC_BYTE) begin
                    state_d    = ST_LEN_LO;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                    idle_d     = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (rx_valid) begin
                    len_d = new_len;
                    if (new_len == 16'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (32'(new_len) > 32'(ROM_WORDS)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Leave DATA only after the last write strobe has been driven from this state
                if (wr_en_q && 32'(word_idx_q) == 32'(len_q)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`endif
                end else if (rx_valid) begin
                    asm_d      = {rx_data, asm_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q + rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_addr(INST_ADDR_BUS'(word_idx_q));
                        wr_data_d  = {rx_data, asm_q[31:8]};
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    busy_d = 1'b0;
                    if (rx_data == csum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides any progress made this cycle
        if (in_frame && (frame_err || (!rx_valid && idle_q == TO_LAST))) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            wr_en_d = 1'b0;
        end
    end

    // State registers; reset abandons any partial frame (ROM contents are left as written)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            idle_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            idle_q     <= idle_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign rom.wr_en   = wr_en_q;
    assign rom.wr_addr = wr_addr_q;
    assign rom.wr_data = wr_data_q;
    assign rom.busy    = busy_q;
    assign rom.done    = done_q;
    assign rom.err     = err_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: frame vectors from a table plus timeout, line-error and reset sequences.
module tb_uart_rom_loader;

    localparam int CLK_FREQ    = 1600;
    localparam int BAUD        = 100;
    localparam int CPB         = CLK_FREQ / BAUD;
    localparam int ROM_WORDS   = 4096;
    localparam int TIMEOUT_CYC = 1000;
`ifdef LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uart_rx_i = 1'b1;

    uart_rom_loader_if rom_bus();

    uart_rom_loader #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .ROM_WORDS   (ROM_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx_i (uart_rx_i),
        .rom       (rom_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  b [12];
        int          nw;
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        done;
        logic        err;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    logic [63:0] wlog [$];
    int checks = 0;
    int errors = 0;

    // Record every write strobe seen on the ROM port
    always @(negedge clk) begin
        if (rom_bus.wr_en === 1'b1) wlog.push_back({rom_bus.wr_addr, rom_bus.wr_data});
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_writes(input string nm, input int k, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] w;
        w = (k < wlog.size()) ? wlog[k] : 64'hxxxx_xxxx_xxxx_xxxx;
        check({nm, "_addr"}, w[63:32], a);
        check({nm, "_data"}, w[31:0], d);
    endtask

    initial begin
        // Two-word program, sync byte A5 also appears nowhere in data
        vecs[0].n  = 11 + CS;
        vecs[0].b  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                       8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        vecs[0].nw = 2;
        vecs[0].a  = '{32'h0, 32'h4};
        vecs[0].d  = '{32'h0000_0013, 32'h0010_0093};
        vecs[0].done = 1'b1; vecs[0].err = 1'b0;
        // Junk before sync is ignored; zero length completes with no writes
        vecs[1].n  = 5;
        vecs[1].b  = '{8'h55, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        vecs[1].nw = 0;
        vecs[1].a  = '{32'h0, 32'h0};
        vecs[1].d  = '{32'h0, 32'h0};
        vecs[1].done = 1'b1; vecs[1].err = 1'b0;
        // Length 4097 exceeds the ROM
        vecs[2].n  = 3;
        vecs[2].b  = '{8'hA5, 8'h01, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        vecs[2].nw = 0;
        vecs[2].a  = '{32'h0, 32'h0};
        vecs[2].d  = '{32'h0, 32'h0};
        vecs[2].done = 1'b0; vecs[2].err = 1'b1;
        // One word after an error clears the error; byte order little-endian
        vecs[3].n  = 7 + CS;
        vecs[3].b  = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38, 8'h0, 8'h0, 8'h0, 8'h0};
        vecs[3].nw = 1;
        vecs[3].a  = '{32'h0, 32'h0};
        vecs[3].d  = '{32'hDEAD_BEEF, 32'h0};
        vecs[3].done = 1'b1; vecs[3].err = 1'b0;
        // Sync value inside data is plain data
        vecs[4].n  = 7 + CS;
        vecs[4].b  = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h94, 8'h0, 8'h0, 8'h0, 8'h0};
        vecs[4].nw = 1;
        vecs[4].a  = '{32'h0, 32'h0};
        vecs[4].d  = '{32'hA5A5_A5A5, 32'h0};
        vecs[4].done = 1'b1; vecs[4].err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(rom_bus.wr_en), 32'd0);
        check("rst_busy",  32'(rom_bus.busy),  32'd0);
        check("rst_done",  32'(rom_bus.done),  32'd0);
        check("rst_err",   32'(rom_bus.err),   32'd0);
        check("rst_addr",  rom_bus.wr_addr,    32'd0);
        check("rst_data",  rom_bus.wr_data,    32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < NV; i++) begin
            wlog.delete();
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k], 1'b1);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_nwrites", i), 32'(wlog.size()), 32'(vecs[i].nw));
            for (int k = 0; k < vecs[i].nw; k++)
                check_writes($sformatf("v%0d_w%0d", i, k), k, vecs[i].a[k], vecs[i].d[k]);
            check($sformatf("v%0d_done", i), 32'(rom_bus.done), 32'(vecs[i].done));
            check($sformatf("v%0d_err", i),  32'(rom_bus.err),  32'(vecs[i].err));
            check($sformatf("v%0d_busy", i), 32'(rom_bus.busy), 32'd0);
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: both words still land in ROM, then error
        wlog.delete();
        for (int k = 0; k < 11; k++) send_byte(vecs[0].b[k], 1'b1);
        send_byte(8'hB7, 1'b1);
        repeat (20) @(negedge clk);
        check("csum_bad_nwrites", 32'(wlog.size()), 32'd2);
        check_writes("csum_bad_w1", 1, 32'h4, 32'h0010_0093);
        check("csum_bad_err",  32'(rom_bus.err),  32'd1);
        check("csum_bad_done", 32'(rom_bus.done), 32'd0);
`endif

        // Silence inside a frame: still busy just under the limit, error just over it
        wlog.delete();
        send_byte(8'hA5, 1'b1);
        check("to_busy_after_sync", 32'(rom_bus.busy), 32'd1);
        check("to_done_cleared",    32'(rom_bus.done), 32'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (900) @(negedge clk);
        check("to_err_before", 32'(rom_bus.err),  32'd0);
        check("to_busy_before", 32'(rom_bus.busy), 32'd1);
        repeat (200) @(negedge clk);
        check("to_err_after",  32'(rom_bus.err),  32'd1);
        check("to_busy_after", 32'(rom_bus.busy), 32'd0);
        check("to_nwrites",    32'(wlog.size()),  32'd0);

        // Stop bit low in the middle of a word
        wlog.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        check("fe_err_cleared", 32'(rom_bus.err), 32'd0);
        send_byte(8'h22, 1'b0);
        repeat (20) @(negedge clk);
        check("fe_err",     32'(rom_bus.err),  32'd1);
        check("fe_busy",    32'(rom_bus.busy), 32'd0);
        check("fe_nwrites", 32'(wlog.size()),  32'd0);

        // One-cycle reset after the first word has started
        wlog.delete();
        for (int k = 0; k < 5; k++) send_byte(vecs[0].b[k], 1'b1);
        check("mr_busy_pre", 32'(rom_bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mr_busy", 32'(rom_bus.busy),  32'd0);
        check("mr_done", 32'(rom_bus.done),  32'd0);
        check("mr_err",  32'(rom_bus.err),   32'd0);
        check("mr_wren", 32'(rom_bus.wr_en), 32'd0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < vecs[0].n; k++) send_byte(vecs[0].b[k], 1'b1);
        repeat (20) @(negedge clk);
        check("mr_nwrites", 32'(wlog.size()), 32'd2);
        check_writes("mr_w0", 0, 32'h0, 32'h0000_0013);
        check_writes("mr_w1", 1, 32'h4, 32'h0010_0093);
        check("mr_reload_done", 32'(rom_bus.done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
